// File: rtl/arbiter_pkg.sv
// Shared encodings for the single-port memory arbiter: FSM states,
// transaction owner and the starvation counter width.
package arbiter_pkg;

  localparam int STARVE_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_e;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive data grants taken while a fetch waits.
// at_limit tells the arbiter that the fetch side must win next.
module arb_starve_counter
  import arbiter_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic clear,
  output logic at_limit
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(LIMIT);

  logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins over increment; stop counting once at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LIMIT_C)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit = (cnt_q == LIMIT_C);

endmodule

// File: rtl/single_port_mem_arbiter.sv
// Shares one single-port memory between the fetch and data requesters of
// the core. One transaction in flight at a time; data has priority, but a
// waiting fetch is granted after STARVE_LIMIT back-to-back data grants.
module single_port_mem_arbiter
  import arbiter_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 32,
  parameter int STARVE_LIMIT = 4,
  localparam int NUM_BYTES   = DATA_WIDTH / 8
) (
  input  logic                    clock,
  input  logic                    reset,
  // fetch requester
  input  logic                    i_read,
  input  logic [ADDRESS_BITS-1:0] i_address,
  output logic                    i_accept,
  output logic                    i_valid,
  output logic [DATA_WIDTH-1:0]   i_data_out,
  output logic [ADDRESS_BITS-1:0] i_address_out,
  // data requester
  input  logic                    d_read,
  input  logic                    d_write,
  input  logic [NUM_BYTES-1:0]    d_byte_en,
  input  logic [ADDRESS_BITS-1:0] d_address,
  input  logic [DATA_WIDTH-1:0]   d_data_in,
  output logic                    d_accept,
  output logic                    d_valid,
  output logic [DATA_WIDTH-1:0]   d_data_out,
  output logic [ADDRESS_BITS-1:0] d_address_out,
  // memory side
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [NUM_BYTES-1:0]    mem_byte_en,
  output logic [ADDRESS_BITS-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]   mem_data_out,
  input  logic                    mem_ready,
  input  logic                    mem_valid,
  input  logic [DATA_WIDTH-1:0]   mem_data_in,
  input  logic [ADDRESS_BITS-1:0] mem_address_in
);

  state_e                  state_q, state_d;
  owner_e                  owner_q, owner_d;
  logic                    cmd_read_q, cmd_read_d;
  logic                    cmd_write_q, cmd_write_d;
  logic [NUM_BYTES-1:0]    cmd_byte_en_q, cmd_byte_en_d;
  logic [ADDRESS_BITS-1:0] cmd_address_q, cmd_address_d;
  logic [DATA_WIDTH-1:0]   cmd_data_q, cmd_data_d;
  logic                    i_accept_q, i_accept_d;
  logic                    d_accept_q, d_accept_d;
  logic                    i_valid_q, i_valid_d;
  logic                    d_valid_q, d_valid_d;
  logic [DATA_WIDTH-1:0]   i_data_q, i_data_d;
  logic [ADDRESS_BITS-1:0] i_address_q, i_address_d;
  logic [DATA_WIDTH-1:0]   d_data_q, d_data_d;
  logic [ADDRESS_BITS-1:0] d_address_q, d_address_d;

  logic d_pending, grant_inst, grant_data, capture;
  logic starve_inc, starve_clear, starve_at_limit;

  arb_starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clock   (clock),
    .reset   (reset),
    .inc     (starve_inc),
    .clear   (starve_clear),
    .at_limit(starve_at_limit)
  );

  // Arbitration: data first, unless the fetch side has waited out its limit.
  assign d_pending  = d_read | d_write;
  assign grant_inst = i_read & (~d_pending | starve_at_limit);
  assign grant_data = d_pending & ~grant_inst;

  // Next-state, command latch and response capture.
  // NOTE: every signal assigned here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    cmd_read_d    = cmd_read_q;
    cmd_write_d   = cmd_write_q;
    cmd_byte_en_d = cmd_byte_en_q;
    cmd_address_d = cmd_address_q;
    cmd_data_d    = cmd_data_q;
    i_accept_d    = 1'b0;
    d_accept_d    = 1'b0;
    i_valid_d     = 1'b0;
    d_valid_d     = 1'b0;
    i_data_d      = i_data_q;
    i_address_d   = i_address_q;
    d_data_d      = d_data_q;
    d_address_d   = d_address_q;
    starve_inc    = 1'b0;
    starve_clear  = 1'b0;
    capture       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        starve_clear = ~i_read;
        if (grant_inst) begin
          state_d       = ST_ISSUE;
          owner_d       = OWN_INST;
          cmd_read_d    = 1'b1;
          cmd_write_d   = 1'b0;
          cmd_byte_en_d = '0;
          cmd_address_d = i_address;
          cmd_data_d    = '0;
          i_accept_d    = 1'b1;
          starve_clear  = 1'b1;
        end else if (grant_data) begin
          state_d       = ST_ISSUE;
          owner_d       = OWN_DATA;
          cmd_read_d    = d_read;
          cmd_write_d   = d_write;
          cmd_byte_en_d = d_byte_en;
          cmd_address_d = d_address;
          cmd_data_d    = d_data_in;
          d_accept_d    = 1'b1;
          starve_inc    = i_read;
        end
      end
      ST_ISSUE: begin
        if (mem_ready) begin
          if (mem_valid) begin
            capture = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (mem_valid) begin
          capture = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Route the memory response to whoever owns the transaction.
    if (capture) begin
      owner_d = OWN_NONE;
      if (owner_q == OWN_INST) begin
        i_valid_d   = 1'b1;
        i_data_d    = mem_data_in;
        i_address_d = mem_address_in;
      end else if (owner_q == OWN_DATA) begin
        d_valid_d   = 1'b1;
        d_data_d    = mem_data_in;
        d_address_d = mem_address_in;
      end
    end
  end

  // State, command and response registers; reset drops any in-flight work.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      owner_q       <= OWN_NONE;
      cmd_read_q    <= 1'b0;
      cmd_write_q   <= 1'b0;
      cmd_byte_en_q <= '0;
      cmd_address_q <= '0;
      cmd_data_q    <= '0;
      i_accept_q    <= 1'b0;
      d_accept_q    <= 1'b0;
      i_valid_q     <= 1'b0;
      d_valid_q     <= 1'b0;
      i_data_q      <= '0;
      i_address_q   <= '0;
      d_data_q      <= '0;
      d_address_q   <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      cmd_read_q    <= cmd_read_d;
      cmd_write_q   <= cmd_write_d;
      cmd_byte_en_q <= cmd_byte_en_d;
      cmd_address_q <= cmd_address_d;
      cmd_data_q    <= cmd_data_d;
      i_accept_q    <= i_accept_d;
      d_accept_q    <= d_accept_d;
      i_valid_q     <= i_valid_d;
      d_valid_q     <= d_valid_d;
      i_data_q      <= i_data_d;
      i_address_q   <= i_address_d;
      d_data_q      <= d_data_d;
      d_address_q   <= d_address_d;
    end
  end

  assign i_accept      = i_accept_q;
  assign d_accept      = d_accept_q;
  assign i_valid       = i_valid_q;
  assign d_valid       = d_valid_q;
  assign i_data_out    = i_data_q;
  assign i_address_out = i_address_q;
  assign d_data_out    = d_data_q;
  assign d_address_out = d_address_q;

  assign mem_read     = (state_q == ST_ISSUE) & cmd_read_q;
  assign mem_write    = (state_q == ST_ISSUE) & cmd_write_q;
  assign mem_byte_en  = cmd_byte_en_q;
  assign mem_address  = cmd_address_q;
  assign mem_data_out = cmd_data_q;

endmodule
